// File: rtl/mod_clock_divider_multi.sv
// Multi-channel programmable clock divider with shadowed divisor/mode
// registers, global phase sync and per-channel enables.
module mod_clock_divider_multi #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk_in,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_enable,
  input  logic              i_sync,
  input  logic              i_load,
  input  logic [CW-1:0]     i_load_ch,
  input  logic [WIDTH-1:0]  i_load_div,
  input  logic              i_load_mode,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_tick,
  output logic              o_load_err
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic load_ok;

  assign load_ok = i_load && (32'(i_load_ch) < 32'(NUM_CH));

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      o_load_err <= 1'b0;
    end else begin
      o_load_err <= i_load && !load_ok;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act_div;
    logic [WIDTH-1:0] shd_div;
    logic             act_mode;
    logic             shd_mode;
    logic             clk_q;
    logic             tick_q;
    logic             hold;
    logic             tc;
    logic             run;
    logic             wr;

    assign hold = i_sync || !i_enable[n];
    assign tc   = !hold && (cnt == act_div);
    assign run  = !hold && !tc;
    assign wr   = load_ok && (i_load_ch == CW'(n));

    assign o_clk_out[n] = clk_q;
    assign o_tick[n]    = tick_q;

    always_ff @(posedge i_clk_in or posedge i_rst) begin
      if (i_rst) begin
        cnt      <= '0;
        act_div  <= DEF_DIV;
        shd_div  <= DEF_DIV;
        act_mode <= 1'b0;
        shd_mode <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        if (wr) begin
          shd_div  <= i_load_div;
          shd_mode <= i_load_mode;
        end
        // commits read the shadow as it stood before this edge's load
        unique case (1'b1)
          hold: begin
            cnt      <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            act_div  <= shd_div;
            act_mode <= shd_mode;
          end
          tc: begin
            cnt      <= '0;
            tick_q   <= 1'b1;
            clk_q    <= act_mode ? 1'b1 : ~clk_q;
            act_div  <= shd_div;
            act_mode <= shd_mode;
          end
          run: begin
            cnt    <= cnt + 1'b1;
            tick_q <= 1'b0;
            if (act_mode) clk_q <= 1'b0;
          end
          default: begin
            tick_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
